// File: rtl/ahb_sync_sram.sv
// ahb_sync_sram: zero-wait-state AHB-Lite slave in front of a byte-enabled 1-cycle-latency synchronous SRAM
//   clk, rst_n                    : clock, async active-low reset
//   ahbls_*                       : AHB-Lite slave port (hburst/hprot/hmastlock ignored)
//   sram_addr/wen/wdata, sram_rdata : single-port SRAM, byte write enables, read data one cycle after address
// A write data phase that collides with a read address phase parks in a one-entry buffer,
// which drains on the next cycle without a read and is forwarded to reads that hit it.
module ahb_sync_sram #(
  parameter int W_DATA = 32,
  parameter int W_ADDR = 32,
  parameter int DEPTH  = 1 << 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ahbls_hready,
  output logic                     ahbls_hready_resp,
  output logic                     ahbls_hresp,
  input  logic [W_ADDR-1:0]        ahbls_haddr,
  input  logic                     ahbls_hwrite,
  input  logic [1:0]               ahbls_htrans,
  input  logic [2:0]               ahbls_hsize,
  input  logic [2:0]               ahbls_hburst,
  input  logic [3:0]               ahbls_hprot,
  input  logic                     ahbls_hmastlock,
  input  logic [W_DATA-1:0]        ahbls_hwdata,
  output logic [W_DATA-1:0]        ahbls_hrdata,
  output logic [$clog2(DEPTH)-1:0] sram_addr,
  output logic [W_DATA/8-1:0]      sram_wen,
  output logic [W_DATA-1:0]        sram_wdata,
  input  logic [W_DATA-1:0]        sram_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = W_DATA / 8;
  logic          valid, wr_ap, rd_ap, wph, rph, buf_valid, hit, unused_ok;
  logic [AW-1:0] a_idx, w_addr, r_addr, buf_addr;
  logic [NB-1:0] a_mask, w_mask, buf_mask;
  logic [W_DATA-1:0] buf_data;
  assign valid = ahbls_hready & ahbls_htrans[1];
  assign wr_ap = valid & ahbls_hwrite;
  assign rd_ap = valid & ~ahbls_hwrite;
  assign a_idx = ahbls_haddr[2 +: AW];
  assign a_mask = ahbls_hsize[2:1] != 2'b00 ? 4'hf :
                  ahbls_hsize[0] ? (ahbls_haddr[1] ? 4'hc : 4'h3) : 4'h1 << ahbls_haddr[1:0];
  assign ahbls_hready_resp = 1'b1;
  assign ahbls_hresp = 1'b0;
  assign unused_ok = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_haddr[W_ADDR-1:AW+2]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wph       <= 1'b0;
      rph       <= 1'b0;
      buf_valid <= 1'b0;
      w_addr    <= '0;
      r_addr    <= '0;
      buf_addr  <= '0;
      w_mask    <= '0;
      buf_mask  <= '0;
      buf_data  <= '0;
    end else begin
      wph <= wr_ap;
      rph <= rd_ap;
      if (wr_ap) begin
        w_addr <= a_idx;
        w_mask <= a_mask;
      end
      if (rd_ap) r_addr <= a_idx;
      if (wph && rd_ap) begin
        buf_valid <= 1'b1;
        buf_addr  <= w_addr;
        buf_mask  <= w_mask;
        buf_data  <= ahbls_hwdata;
      end else if (!rd_ap) buf_valid <= 1'b0;
    end
  always_comb begin
    sram_addr  = rd_ap ? a_idx : wph ? w_addr : buf_valid ? buf_addr : a_idx;
    sram_wen   = rd_ap ? '0 : wph ? w_mask : buf_valid ? buf_mask : '0;
    sram_wdata = wph ? ahbls_hwdata : buf_data;
  end
  assign hit = buf_valid && buf_addr == r_addr;
  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign ahbls_hrdata[8*i +: 8] = !rph ? 8'h00 :
                                    (hit && buf_mask[i]) ? buf_data[8*i +: 8] : sram_rdata[8*i +: 8];
  end
endmodule

// File: tb/tb_ahb_sync_sram.sv
// tb_ahb_sync_sram: directed vector bench for ahb_sync_sram with a behavioural SRAM
module tb_ahb_sync_sram;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        hready = 1'b1, hready_resp, hresp, hwrite = 1'b0, hmastlock = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0, hrdata, sram_wdata, sram_rdata = '0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'd2, hburst = '0;
  logic [3:0]  hprot = '0, sram_wen;
  logic [10:0] sram_addr;
  logic [31:0] mem [2048];
  int total = 0, bad = 0;

  ahb_sync_sram dut (
    .clk(clk), .rst_n(rst_n), .ahbls_hready(hready), .ahbls_hready_resp(hready_resp),
    .ahbls_hresp(hresp), .ahbls_haddr(haddr), .ahbls_hwrite(hwrite), .ahbls_htrans(htrans),
    .ahbls_hsize(hsize), .ahbls_hburst(hburst), .ahbls_hprot(hprot), .ahbls_hmastlock(hmastlock),
    .ahbls_hwdata(hwdata), .ahbls_hrdata(hrdata), .sram_addr(sram_addr), .sram_wen(sram_wen),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 2048; i++) mem[i] = '0;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (sram_wen[i]) mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
    sram_rdata <= mem[sram_addr];
  end

  always @(posedge clk)
    if (rst_n && dut.wph && dut.rd_ap) begin
      total++;
      if (dut.buf_valid) begin
        bad++;
        $display("FAIL buf_invariant: buffer load with buf_valid=%0b required 0", dut.buf_valid);
      end
    end

  typedef struct {
    logic hr; logic [1:0] tr; logic w; logic [31:0] a; logic [2:0] s; logic [31:0] wd;
    logic [3:0] ewen; logic ca; logic [10:0] eaddr; logic [31:0] ewd; logic [31:0] erd;
  } vec_t;
  vec_t v[$];

  localparam logic [1:0] ID = 2'b00, BS = 2'b01, NS = 2'b10;

  function automatic vec_t mk(logic hr, logic [1:0] tr, logic w, logic [31:0] a, logic [2:0] s,
                              logic [31:0] wd, logic [3:0] ewen, logic ca, logic [10:0] eaddr,
                              logic [31:0] ewd, logic [31:0] erd);
    vec_t r;
    r.hr = hr; r.tr = tr; r.w = w; r.a = a; r.s = s; r.wd = wd;
    r.ewen = ewen; r.ca = ca; r.eaddr = eaddr; r.ewd = ewd; r.erd = erd;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic hr, logic [1:0] tr, logic w, logic [31:0] a, logic [2:0] s, logic [31:0] wd);
    hready = hr; htrans = tr; hwrite = w; haddr = a; hsize = s; hwdata = wd;
  endtask

  initial begin
    // word write @0x10, then byte write @0x13 colliding with a word read
    v.push_back(mk(1, NS, 1, 32'h10, 2, 0,            4'h0, 0, 0,  0,            0));
    v.push_back(mk(1, ID, 0, 32'h0,  2, 32'hDEADBEEF, 4'hf, 1, 4,  32'hDEADBEEF, 0));
    v.push_back(mk(1, NS, 1, 32'h13, 0, 0,            4'h0, 0, 0,  0,            0));
    v.push_back(mk(1, NS, 0, 32'h10, 2, 32'hAB000000, 4'h0, 1, 4,  0,            0));
    v.push_back(mk(1, ID, 0, 32'h0,  2, 0,            4'h8, 1, 4,  32'hAB000000, 32'hABADBEEF));
    // back-to-back W/R @0x20 forwarded from the buffer
    v.push_back(mk(1, NS, 1, 32'h20, 2, 0,            4'h0, 0, 0,  0,            0));
    v.push_back(mk(1, NS, 0, 32'h20, 2, 32'h11223344, 4'h0, 1, 8,  0,            0));
    v.push_back(mk(1, ID, 0, 32'h0,  2, 0,            4'hf, 1, 8,  32'h11223344, 32'h11223344));
    // halfword over 0xAAAAAAAA with partial forwarding
    v.push_back(mk(1, NS, 1, 32'h20, 2, 0,            4'h0, 0, 0,  0,            0));
    v.push_back(mk(1, ID, 0, 32'h0,  2, 32'hAAAAAAAA, 4'hf, 1, 8,  32'hAAAAAAAA, 0));
    v.push_back(mk(1, NS, 1, 32'h22, 1, 0,            4'h0, 0, 0,  0,            0));
    v.push_back(mk(1, NS, 0, 32'h20, 2, 32'h55660000, 4'h0, 1, 8,  0,            0));
    v.push_back(mk(1, ID, 0, 32'h0,  2, 0,            4'hc, 1, 8,  32'h55660000, 32'h5566AAAA));
    v.push_back(mk(1, NS, 0, 32'h20, 2, 0,            4'h0, 1, 8,  0,            0));
    v.push_back(mk(1, ID, 0, 32'h0,  2, 0,            4'h0, 0, 0,  0,            32'h5566AAAA));
    // W @0x40 held across three reads, committed on IDLE
    v.push_back(mk(1, NS, 1, 32'h40, 2, 0,            4'h0, 0, 0,  0,            0));
    v.push_back(mk(1, NS, 0, 32'h10, 2, 32'hCAFEF00D, 4'h0, 1, 4,  0,            0));
    v.push_back(mk(1, NS, 0, 32'h20, 2, 0,            4'h0, 1, 8,  0,            32'hABADBEEF));
    v.push_back(mk(1, NS, 0, 32'h40, 2, 0,            4'h0, 1, 16, 0,            32'h5566AAAA));
    v.push_back(mk(1, ID, 0, 32'h0,  2, 0,            4'hf, 1, 16, 32'hCAFEF00D, 32'hCAFEF00D));
    v.push_back(mk(1, NS, 0, 32'h40, 2, 0,            4'h0, 1, 16, 0,            0));
    v.push_back(mk(1, ID, 0, 32'h0,  2, 0,            4'h0, 0, 0,  0,            32'hCAFEF00D));
    // high address bits alias
    v.push_back(mk(1, NS, 0, 32'h80000040, 2, 0,      4'h0, 1, 16, 0,            0));
    v.push_back(mk(1, ID, 0, 32'h0,  2, 0,            4'h0, 0, 0,  0,            32'hCAFEF00D));
    // hready low and BUSY produce no write
    v.push_back(mk(0, NS, 1, 32'h10, 2, 0,            4'h0, 0, 0,  0,            0));
    v.push_back(mk(1, ID, 0, 32'h0,  2, 32'h12345678, 4'h0, 0, 0,  0,            0));
    v.push_back(mk(1, BS, 1, 32'h10, 2, 0,            4'h0, 0, 0,  0,            0));
    v.push_back(mk(1, ID, 0, 32'h0,  2, 32'h12345678, 4'h0, 0, 0,  0,            0));
    v.push_back(mk(1, NS, 0, 32'h10, 2, 0,            4'h0, 1, 4,  0,            0));
    v.push_back(mk(1, ID, 0, 32'h0,  2, 0,            4'h0, 0, 0,  0,            32'hABADBEEF));
    // byte lane 1, halfword with misaligned low bit, word with misaligned address
    v.push_back(mk(1, NS, 1, 32'h41, 0, 0,            4'h0, 0, 0,  0,            0));
    v.push_back(mk(1, ID, 0, 32'h0,  2, 32'h0000EE00, 4'h2, 1, 16, 32'h0000EE00, 0));
    v.push_back(mk(1, NS, 1, 32'h43, 1, 0,            4'h0, 0, 0,  0,            0));
    v.push_back(mk(1, ID, 0, 32'h0,  2, 32'h77880000, 4'hc, 1, 16, 32'h77880000, 0));
    v.push_back(mk(1, NS, 0, 32'h40, 2, 0,            4'h0, 1, 16, 0,            0));
    v.push_back(mk(1, ID, 0, 32'h0,  2, 0,            4'h0, 0, 0,  0,            32'h7788EE0D));
    v.push_back(mk(1, NS, 1, 32'h46, 2, 0,            4'h0, 0, 0,  0,            0));
    v.push_back(mk(1, ID, 0, 32'h0,  2, 32'h99999999, 4'hf, 1, 17, 32'h99999999, 0));

    // reset state, with a write address phase presented during reset
    drive(1, NS, 1, 32'h10, 2, 32'hFFFFFFFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wen", {28'h0, sram_wen}, 0);
    chk("rst_hrdata", hrdata, 0);
    chk("rst_resp", {30'h0, hready_resp, hresp}, 32'h2);
    chk("rst_buf_valid", {31'h0, dut.buf_valid}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1, ID, 0, 0, 2, 0);
    @(posedge clk); #1;

    foreach (v[i]) begin
      drive(v[i].hr, v[i].tr, v[i].w, v[i].a, v[i].s, v[i].wd);
      @(negedge clk);
      chk($sformatf("row%0d_wen", i), {28'h0, sram_wen}, {28'h0, v[i].ewen});
      if (v[i].ca) chk($sformatf("row%0d_addr", i), {21'h0, sram_addr}, {21'h0, v[i].eaddr});
      if (v[i].ewen != 0) chk($sformatf("row%0d_wdata", i), sram_wdata, v[i].ewd);
      chk($sformatf("row%0d_hrdata", i), hrdata, v[i].erd);
      chk($sformatf("row%0d_resp", i), {30'h0, hready_resp, hresp}, 32'h2);
      @(posedge clk); #1;
    end

    // reset with a loaded buffer discards it
    drive(1, NS, 1, 32'h60, 2, 0);
    @(posedge clk); #1;
    drive(1, NS, 0, 32'h60, 2, 32'h0BADF00D);
    @(negedge clk);
    chk("mr_collide_wen", {28'h0, sram_wen}, 0);
    @(posedge clk); #1;
    chk("mr_buf_loaded", {31'h0, dut.buf_valid}, 1);
    drive(1, ID, 0, 0, 2, 0);
    rst_n = 1'b0;
    #1;
    chk("mr_buf_cleared", {31'h0, dut.buf_valid}, 0);
    chk("mr_wen", {28'h0, sram_wen}, 0);
    chk("mr_hrdata", hrdata, 0);
    repeat (2) begin
      @(negedge clk);
      chk("mr_hold_wen", {28'h0, sram_wen}, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_post_wen", {28'h0, sram_wen}, 0);
    chk("mr_post_hrdata", hrdata, 0);
    chk("mr_post_buf_valid", {31'h0, dut.buf_valid}, 0);
    @(posedge clk); #1;
    chk("mr_sram_untouched", mem[24], 0);
    drive(1, NS, 0, 32'h60, 2, 0);
    @(posedge clk); #1;
    drive(1, ID, 0, 0, 2, 0);
    @(negedge clk);
    chk("mr_readback", hrdata, 0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
